// File: rtl/johnson_phase_decoder.sv
// ---------------------------------------------------------------------------
// johnson_phase_decoder
//
// Purpose:
//   Watches the N-bit bus of the upstream Johnson counter and turns it into
//   the timing slots used by the phase-sequenced control logic.
//   - Samples `count` on every clock.
//   - Decodes it to a phase index and a one-hot phase vector.
//   - Checks that the code is legal and that each step is a hold or a single
//     forward step.
//   - Emits one wrap strobe per full 2N-phase revolution.
//   - Keeps revolution and error statistics.
//   Every output is registered, one clock after the sample it describes.
//
// Ports:
//   clock        rising-edge clock, same domain as the Johnson counter
//   reset        asynchronous, active-low reset
//   count        Johnson code from the upstream counter (N bits)
//   clear_err    synchronous clear of err_sticky and err_count
//   phase_idx    decoded phase 0..2N-1, holds last legal value on bad code
//   phase_onehot bit phase_idx set when code_valid, otherwise all zero
//   code_valid   sampled code was a legal Johnson state
//   wrap         one-cycle pulse on a phase 2N-1 -> 0 transition
//   seq_err      one-cycle pulse: legal code, but neither a hold nor +1 step
//   err_sticky   set by any error event, cleared by clear_err or reset
//   err_count    saturating count of error events (ERR_W bits)
//   cycle_count  number of wrap events, modulo 2^CNT_W
// ---------------------------------------------------------------------------
module johnson_phase_decoder #(
  parameter int N     = 10,
  parameter int IDX_W = $clog2(2 * N),
  parameter int ERR_W = 8,
  parameter int CNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N-1:0]       count,
  input  logic               clear_err,
  output logic [IDX_W-1:0]   phase_idx,
  output logic [2*N-1:0]     phase_onehot,
  output logic               code_valid,
  output logic               wrap,
  output logic               seq_err,
  output logic               err_sticky,
  output logic [ERR_W-1:0]   err_count,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam int                PHASES   = 2 * N;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PHASES - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

  // Reference Johnson pattern for phase k.
  // - Up to phase N, ones fill in from the bottom.
  // - Past phase N, zeros fill in from the bottom.
  function automatic logic [N-1:0] phase_code(input int k);
    logic [N-1:0] c;
    c = '0;
    for (int b = 0; b < N; b++) begin
      if (k <= N) c[b] = (b < k);
      else        c[b] = (b >= k - N);
    end
    return c;
  endfunction

  logic [IDX_W-1:0] prev_idx;
  logic             prev_valid;

  logic             cur_legal;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] next_idx;
  logic             seq_bad;
  logic             err_event;
  logic             is_wrap;

  // Compare the sample against every legal pattern.
  // - Legal patterns are distinct, so at most one can match.
  // - A bus that matches none is illegal.
  always_comb begin
    cur_legal = 1'b0;
    cur_idx   = '0;
    for (int k = 0; k < PHASES; k++) begin
      if (count == phase_code(k)) begin
        cur_legal = 1'b1;
        cur_idx   = IDX_W'(k);
      end
    end
  end

  // Step check against the last legal phase.
  // - A hold is accepted because the upstream counter may be paused.
  // - An illegal sample never counts as a seq_err; it is reported as its own
  //   error, so each cycle raises at most one error event.
  always_comb begin
    next_idx  = (prev_idx == LAST_IDX) ? '0 : prev_idx + 1'b1;
    seq_bad   = prev_valid && cur_legal &&
                (cur_idx != prev_idx) && (cur_idx != next_idx);
    err_event = !cur_legal || seq_bad;
    is_wrap   = prev_valid && cur_legal &&
                (prev_idx == LAST_IDX) && (cur_idx == '0);
  end

  // Registered outputs and tracking state.
  // - When an error event and clear_err arrive in the same cycle, the error
  //   wins: the statistics restart at one instead of zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_idx    <= '0;
      phase_onehot <= '0;
      code_valid   <= 1'b0;
      wrap         <= 1'b0;
      seq_err      <= 1'b0;
      err_sticky   <= 1'b0;
      err_count    <= '0;
      cycle_count  <= '0;
      prev_idx     <= '0;
      prev_valid   <= 1'b0;
    end else begin
      code_valid <= cur_legal;
      seq_err    <= seq_bad;
      wrap       <= is_wrap;

      if (cur_legal) begin
        phase_idx    <= cur_idx;
        phase_onehot <= (2 * N)'(1) << cur_idx;
        prev_idx     <= cur_idx;
        prev_valid   <= 1'b1;
      end else begin
        phase_onehot <= '0;
        prev_valid   <= 1'b0;
      end

      if (is_wrap) begin
        cycle_count <= cycle_count + 1'b1;
      end

      if (err_event) begin
        err_sticky <= 1'b1;
        if (clear_err) begin
          err_count <= ERR_W'(1);
        end else if (err_count != ERR_MAX) begin
          err_count <= err_count + 1'b1;
        end
      end else if (clear_err) begin
        err_sticky <= 1'b0;
        err_count  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// ---------------------------------------------------------------------------
// tb_johnson_phase_decoder
//
// Directed bench for johnson_phase_decoder (N=10).
// - Expected Johnson codes come from walking the upstream next-state rule
//   from phase 0.
// - Expected phases and statistics are worked out by hand for each step.
// ---------------------------------------------------------------------------
module tb_johnson_phase_decoder;

  localparam int N     = 10;
  localparam int IDX_W = 5;
  localparam int ERR_W = 8;
  localparam int CNT_W = 16;

  logic               clock;
  logic               reset;
  logic [N-1:0]       count;
  logic               clear_err;
  logic [IDX_W-1:0]   phase_idx;
  logic [2*N-1:0]     phase_onehot;
  logic               code_valid;
  logic               wrap;
  logic               seq_err;
  logic               err_sticky;
  logic [ERR_W-1:0]   err_count;
  logic [CNT_W-1:0]   cycle_count;

  int assertCount;
  int failCount;

  localparam logic [N-1:0] ILLEGAL = 10'b0000000101;

  johnson_phase_decoder #(
    .N    (N),
    .IDX_W(IDX_W),
    .ERR_W(ERR_W),
    .CNT_W(CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .count       (count),
    .clear_err   (clear_err),
    .phase_idx   (phase_idx),
    .phase_onehot(phase_onehot),
    .code_valid  (code_valid),
    .wrap        (wrap),
    .seq_err     (seq_err),
    .err_sticky  (err_sticky),
    .err_count   (err_count),
    .cycle_count (cycle_count)
  );

  // 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Code for phase k, built by stepping the upstream rule
  // next = {c[N-2:0], ~c[N-1]} k times from all-zeros.
  function automatic logic [N-1:0] johnsonCode(input int k);
    logic [N-1:0] c;
    c = '0;
    for (int i = 0; i < k; i++) c = {c[N-2:0], ~c[N-1]};
    return c;
  endfunction

  // Drive one sample away from the edge, clock it in, then settle 1 ns
  // past the edge so the registered outputs can be read.
  task automatic applyStimulus(input logic [N-1:0] code, input logic clr);
    count     = code;
    clear_err = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkErr(input string tag, input logic s, input int c);
    checkOutput({tag, " err_sticky"}, 32'(err_sticky), 32'(s));
    checkOutput({tag, " err_count"},  32'(err_count),  32'(c));
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b0;
    count       = '0;
    clear_err   = 1'b0;

    // Reset state.
    #3;
    checkOutput("rst phase_idx",    32'(phase_idx),    0);
    checkOutput("rst phase_onehot", 32'(phase_onehot), 0);
    checkOutput("rst code_valid",   32'(code_valid),   0);
    checkOutput("rst cycle_count",  32'(cycle_count),  0);
    checkErr("rst", 1'b0, 0);
    @(negedge clock);
    reset = 1'b1;

    // Two full revolutions plus the closing phase 0.
    // The first 0 follows reset, so only the later 19->0 steps wrap.
    $display("[TB] full revolutions");
    for (int rev = 0; rev < 2; rev++) begin
      for (int k = 0; k < 2 * N; k++) begin
        applyStimulus(johnsonCode(k), 1'b0);
        checkOutput($sformatf("rev%0d k%0d phase_idx", rev, k),
                    32'(phase_idx), 32'(k));
        checkOutput($sformatf("rev%0d k%0d onehot", rev, k),
                    32'(phase_onehot), 32'(1) << k);
        checkOutput($sformatf("rev%0d k%0d wrap", rev, k),
                    32'(wrap), 32'(k == 0 && rev > 0));
        checkOutput($sformatf("rev%0d k%0d seq_err", rev, k),
                    32'(seq_err), 0);
      end
    end
    applyStimulus(johnsonCode(0), 1'b0);
    checkOutput("final wrap",        32'(wrap),        1);
    checkOutput("final cycle_count", 32'(cycle_count), 2);
    checkErr("revs", 1'b0, 0);
    applyStimulus(johnsonCode(1), 1'b0);
    checkOutput("wrap pulse ends", 32'(wrap), 0);
    checkOutput("cycle_count holds", 32'(cycle_count), 2);

    // Hold phase 3 for five clocks, then step to 4.
    $display("[TB] hold then step");
    applyStimulus(johnsonCode(2), 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(10'b0000000111, 1'b0);
      checkOutput($sformatf("hold%0d phase_idx", i), 32'(phase_idx), 3);
      checkOutput($sformatf("hold%0d seq_err", i),   32'(seq_err),   0);
    end
    applyStimulus(10'b0000001111, 1'b0);
    checkOutput("step4 phase_idx", 32'(phase_idx), 4);
    checkOutput("step4 seq_err",   32'(seq_err),   0);
    checkErr("step4", 1'b0, 0);

    // Backward 4->3 is a sequence error.
    // Holding 3 with clear_err then wipes the statistics.
    applyStimulus(10'b0000000111, 1'b0);
    checkOutput("back seq_err", 32'(seq_err), 1);
    checkErr("back", 1'b1, 1);
    applyStimulus(10'b0000000111, 1'b1);
    checkOutput("clr seq_err", 32'(seq_err), 0);
    checkErr("clr", 1'b0, 0);

    // Jump 3 -> 6.
    $display("[TB] skip 3 to 6");
    applyStimulus(10'b0000111111, 1'b0);
    checkOutput("skip seq_err",    32'(seq_err),    1);
    checkOutput("skip phase_idx",  32'(phase_idx),  6);
    checkOutput("skip code_valid", 32'(code_valid), 1);
    checkErr("skip", 1'b1, 1);
    applyStimulus(10'b0000111111, 1'b0);
    checkOutput("skip pulse ends", 32'(seq_err), 0);

    // Reach phase 2 (6->2 errors, but clear_err loses to the error).
    // Then clear while holding phase 2.
    applyStimulus(johnsonCode(2), 1'b1);
    checkErr("err+clr", 1'b1, 1);
    applyStimulus(johnsonCode(2), 1'b1);
    checkErr("hold clr", 1'b0, 0);

    // Illegal code between phases 2 and 4.
    $display("[TB] illegal injection");
    applyStimulus(ILLEGAL, 1'b0);
    checkOutput("ill code_valid", 32'(code_valid),   0);
    checkOutput("ill onehot",     32'(phase_onehot), 0);
    checkOutput("ill phase_idx",  32'(phase_idx),    2);
    checkOutput("ill seq_err",    32'(seq_err),      0);
    checkErr("ill", 1'b1, 1);
    applyStimulus(johnsonCode(4), 1'b0);
    checkOutput("post-ill seq_err",    32'(seq_err),    0);
    checkOutput("post-ill phase_idx",  32'(phase_idx),  4);
    checkOutput("post-ill code_valid", 32'(code_valid), 1);
    checkErr("post-ill", 1'b1, 1);

    // Saturation: 1 + 300 errors pins the count at 255.
    $display("[TB] saturation");
    for (int i = 0; i < 300; i++) applyStimulus(ILLEGAL, 1'b0);
    checkErr("sat", 1'b1, 255);
    applyStimulus(ILLEGAL, 1'b1);
    checkErr("sat+clr", 1'b1, 1);
    applyStimulus(johnsonCode(0), 1'b1);
    checkOutput("clr-only seq_err", 32'(seq_err), 0);
    checkErr("clr-only", 1'b0, 0);

    // Mid-stream asynchronous reset.
    // The bus sits at phase 5 with err_count=3 when reset is pulled.
    $display("[TB] mid-stream reset");
    for (int i = 0; i < 3; i++) applyStimulus(ILLEGAL, 1'b0);
    applyStimulus(10'b0000011111, 1'b0);
    checkErr("pre-rst", 1'b1, 3);
    checkOutput("pre-rst phase_idx", 32'(phase_idx), 5);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async phase_idx",   32'(phase_idx),    0);
    checkOutput("async onehot",      32'(phase_onehot), 0);
    checkOutput("async code_valid",  32'(code_valid),   0);
    checkOutput("async cycle_count", 32'(cycle_count),  0);
    checkErr("async", 1'b0, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("restart phase_idx",  32'(phase_idx),  5);
    checkOutput("restart code_valid", 32'(code_valid), 1);
    checkOutput("restart seq_err",    32'(seq_err),    0);
    checkOutput("restart onehot",     32'(phase_onehot), 32'(1) << 5);
    checkErr("restart", 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/johnson_phase_decoder.md
Name: johnson_phase_decoder

Overview:
- Downstream consumer of the N-bit Johnson counter: samples its `count` bus every clock and decodes it to a phase index and a one-hot phase vector.
- Checks code legality and step ordering.
- Emits a wrap strobe per full 2N-phase revolution and keeps revolution and error statistics.
- Sits between the Johnson counter and the phase-sequenced control logic that consumes one-hot timing slots.

Parameters:
- N, 10, width of the Johnson code input; 2N legal phases.
- IDX_W, $clog2(2*N), width of phase_idx (5 for N=10).
- ERR_W, 8, width of the saturating error counter.
- CNT_W, 16, width of the revolution counter (wraps modulo 2^CNT_W).

Ports:
- clock  input  1  rising-edge clock, same domain as the Johnson counter.
- reset  input  1  asynchronous, active-low reset.
- count  input  N  Johnson code from the upstream counter.
- clear_err  input  1  synchronous clear of err_sticky and err_count.
- phase_idx  output  IDX_W  decoded phase 0..2N-1; holds the last legal value on an illegal code.
- phase_onehot  output  2N  bit phase_idx set when code_valid=1; all zero otherwise.
- code_valid  output  1  the sampled code was legal.
- wrap  output  1  one-cycle pulse on a phase 2N-1 -> 0 transition.
- seq_err  output  1  one-cycle pulse: legal code, but not a hold or a single forward step.
- err_sticky  output  1  set by any illegal code or seq_err; cleared only by clear_err or reset.
- err_count  output  ERR_W  saturating count of error events.
- cycle_count  output  CNT_W  number of wrap events, modulo 2^CNT_W.

Behaviour:
- Reset (reset=0, asynchronous): every output and internal register is 0, including prev_valid and prev_idx. Releasing reset mid-operation restarts as if from power-up.
- All outputs are registered. Latency is 1 clock from a count sample to the corresponding outputs.
- Code order (matches upstream): next = {count[N-2:0], ~count[N-1]}.
- Legal code definition:
  - Phase k, 0<=k<=N: bits [k-1:0]=1, all others 0.
  - Phase k, N<k<2N: bits [N-1:k-N]=1, bits below are 0.
  - Any other pattern is illegal.
  - N=4 sequence: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000.
- Legal sample with phase k:
  - code_valid=1, phase_idx=k, phase_onehot=1<<k.
  - prev_idx<=k, prev_valid<=1.
- Illegal sample:
  - code_valid=0, phase_onehot=0, phase_idx holds.
  - Error event raised; prev_valid<=0.
- Sequence check, only when prev_valid=1 and the current sample is legal:
  - Allowed: k==prev_idx (hold; the upstream counter may be disabled) or k==(prev_idx+1) mod 2N.
  - Anything else: seq_err=1 for one cycle and an error event is raised.
- No sequence check on the first legal sample after reset or after an illegal sample.
- wrap=1 when prev_valid=1, prev_idx=2N-1 and k=0. cycle_count increments on the same edge and wraps to 0 after 2^CNT_W-1.
- Error event handling: err_sticky<=1; err_count increments and saturates at 2^ERR_W-1.
- clear_err=1 zeroes err_sticky and err_count on the next edge.
- clear_err together with an error event in the same cycle: the error wins, so err_sticky=1 and err_count=1.
- Phase tracking, wrap and cycle_count are unaffected by clear_err.
- Illegal and seq_err are mutually exclusive: at most one error event per cycle.

Test Plan:
- Reset asserted mid-stream, with count=0000011111 and err_count=3 -> all outputs 0 asynchronously; after release, the first sample 0000011111 gives phase_idx=5, code_valid=1, seq_err=0.
- Drive the full 20-phase sequence from 0 twice, one phase per clock (N=10) -> phase_onehot walks bit 0..19; wrap pulses exactly on the 19->0 transition; cycle_count=2; err_count=0.
- Hold count=0000000111 for 5 clocks, then 0000001111 -> phase_idx 3 then 4; no seq_err.
- Step from phase 3 (0000000111) directly to phase 6 (0000111111) -> seq_err pulse one cycle after the sample, err_sticky=1, err_count=1, phase_idx=6.
- Inject illegal 0000000101 between phase 2 and phase 4 -> code_valid=0, phase_onehot=0, phase_idx stays 2, err_count=1; the next sample (phase 4) gives no seq_err.
- Drive 300 illegal samples -> err_count saturates at 255. Then assert clear_err on the same cycle as another illegal sample -> err_count=1, err_sticky=1. Then assert clear_err alone -> 0, 0.
